// File: rtl/wr_ingress.sv
// Write-domain ingress of the async FIFO: a 2-entry skid buffer that feeds the
// full stage with wr_rq, drives the RAM write port and keeps write/stall statistics.
module wr_ingress #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             w_clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             wr_rq,
    input  logic             full,
    input  logic [AW-1:0]    waddr,
    output logic             mem_we,
    output logic [AW-1:0]    mem_waddr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stalled
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_head;
    logic [WIDTH-1:0]   r_tail;
    logic [WIDTH-1:0]   w_head_nxt;
    logic [WIDTH-1:0]   w_tail_nxt;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_stalled;

    logic               w_in_ready;
    logic               w_wr_rq;
    logic               w_commit;
    logic               w_accept;
    logic               w_stall;

    // Both handshakes are masked during reset so a buffered word is discarded
    // rather than written; in_ready never looks at full.
    assign w_in_ready = !rst && (r_state != TWO);
    assign w_wr_rq    = !rst && (r_state != EMPTY);
    assign w_commit   = w_wr_rq && !full;
    assign w_accept   = in_valid && w_in_ready;
    assign w_stall    = w_wr_rq && full;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ONE;
                    w_head_nxt  = in_data;
                end
            end
            ONE: begin
                if (w_accept && w_commit) begin
                    w_head_nxt = in_data;
                end else if (w_accept) begin
                    w_state_nxt = TWO;
                    w_tail_nxt  = in_data;
                end else if (w_commit) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_commit) begin
                    w_state_nxt = ONE;
                    w_head_nxt  = r_tail;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge w_clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state     <= EMPTY;
            r_head      <= '0;
            r_tail      <= '0;
            r_wr_cnt    <= '0;
            r_stall_cnt <= '0;
            r_stalled   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            if (w_commit) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_stall) begin
                r_stalled <= 1'b1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign wr_rq     = w_wr_rq;
    assign mem_we    = w_commit;
    assign mem_waddr = waddr;
    assign mem_wdata = r_head;
    assign wr_cnt    = r_wr_cnt;
    assign stall_cnt = r_stall_cnt;
    assign stalled   = r_stalled;

endmodule

// File: tb/tb_wr_ingress.sv
// Directed bench for wr_ingress: models the full stage's waddr and logs RAM writes.
// A second instance with 4-bit counters shares the stimulus to exercise wrap and saturation.
module tb_wr_ingress;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             w_clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             full;
    logic [AW-1:0]    waddr;

    logic             in_ready, wr_rq, mem_we, stalled;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [15:0]      wr_cnt, stall_cnt;

    logic             in_ready4, wr_rq4, mem_we4, stalled4;
    logic [AW-1:0]    mem_waddr4;
    logic [WIDTH-1:0] mem_wdata4;
    logic [3:0]       wr_cnt4, stall_cnt4;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] wq[$];
    logic [AW-1:0]    aq[$];

    wr_ingress #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .w_clk(w_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .wr_rq(wr_rq), .full(full), .waddr(waddr),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wr_cnt(wr_cnt), .stall_cnt(stall_cnt), .stalled(stalled)
    );

    wr_ingress #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .w_clk(w_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .wr_rq(wr_rq4), .full(full), .waddr(waddr),
        .mem_we(mem_we4), .mem_waddr(mem_waddr4), .mem_wdata(mem_wdata4),
        .wr_cnt(wr_cnt4), .stall_cnt(stall_cnt4), .stalled(stalled4)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Logs this cycle's RAM write, crosses the edge, then advances the modelled waddr.
    task automatic step();
        logic adv;
        #1;
        adv = (mem_we === 1'b1);
        if (adv) begin
            wq.push_back(mem_wdata);
            aq.push_back(mem_waddr);
        end
        @(posedge w_clk);
        #1;
        if (adv) waddr = waddr + 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] seq [6];
        int               idx;
        logic             acc;
        seq[0] = 4'h3; seq[1] = 4'hE; seq[2] = 4'h7;
        seq[3] = 4'h0; seq[4] = 4'hF; seq[5] = 4'h9;

        // Reset held for 3 cycles with in_valid high
        rst = 1'b1; in_valid = 1'b1; in_data = 4'h5; full = 1'b0; waddr = '0;
        repeat (3) step();
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_rq", wr_rq, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_wr_cnt", wr_cnt, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_stalled", stalled, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        step();

        // Streaming 1..8 from waddr 0
        for (int i = 1; i <= 9; i++) begin
            in_valid = (i <= 8);
            in_data  = WIDTH'(i);
            #1;
            check("stream_we", mem_we, (i > 1) ? 1 : 0);
            if (i > 1) begin
                check("stream_wdata", mem_wdata, i - 1);
                check("stream_waddr", mem_waddr, i - 2);
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        check("stream_idle_we", mem_we, 0);
        check("stream_idle_wr_rq", wr_rq, 0);
        check("stream_wr_cnt", wr_cnt, 8);
        check("stream_wrapped_waddr", mem_waddr, 0);

        // Backpressure: full held, A and B accepted, C refused
        full = 1'b1; in_valid = 1'b1; in_data = 4'hA;
        #1;
        check("bp_a_ready", in_ready, 1);
        step();
        in_data = 4'hB;
        #1;
        check("bp_b_ready", in_ready, 1);
        check("bp_b_wr_rq", wr_rq, 1);
        check("bp_b_we", mem_we, 0);
        check("bp_b_head", mem_wdata, 4'hA);
        step();
        in_data = 4'hC;
        #1;
        check("bp_c_ready", in_ready, 0);
        check("bp_c_we", mem_we, 0);
        check("bp_c_head", mem_wdata, 4'hA);
        step();
        #1;
        check("bp_stall_cnt", stall_cnt, 2);
        check("bp_stalled", stalled, 1);
        step();
        full = 1'b0;
        #1;
        check("bp_rel_a_we", mem_we, 1);
        check("bp_rel_a_data", mem_wdata, 4'hA);
        check("bp_rel_a_addr", mem_waddr, 0);
        check("bp_rel_a_ready", in_ready, 0);
        step();
        #1;
        check("bp_rel_b_data", mem_wdata, 4'hB);
        check("bp_rel_b_addr", mem_waddr, 1);
        check("bp_rel_c_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        #1;
        check("bp_rel_c_we", mem_we, 1);
        check("bp_rel_c_data", mem_wdata, 4'hC);
        check("bp_rel_c_addr", mem_waddr, 2);
        step();
        #1;
        check("bp_wr_cnt", wr_cnt, 11);
        check("bp_stall_total", stall_cnt, 3);
        check("bp_idle_wr_rq", wr_rq, 0);

        // full toggling every cycle with continuous in_valid
        wq.delete(); aq.delete();
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            full     = c[0];
            in_valid = (idx < 6);
            in_data  = (idx < 6) ? seq[idx] : 4'h0;
            #1;
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        full = 1'b0; in_valid = 1'b0;
        #1;
        check("tog_accepted", idx, 6);
        check("tog_writes", wq.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < wq.size()) begin
                check("tog_order_data", wq[k], seq[k]);
                check("tog_order_addr", aq[k], (3 + k) % DEPTH);
            end
        end
        check("tog_wr_cnt", wr_cnt, 17);
        check("tog_wr_cnt4_wrap", wr_cnt4, 1);
        check("tog_stall_cnt", stall_cnt, 9);
        check("tog_wr_rq", wr_rq, 0);

        // Saturation: one word parked behind full
        full = 1'b1; in_valid = 1'b1; in_data = 4'h5;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #1;
        check("sat_mid_cnt4", stall_cnt4, 14);
        check("sat_mid_cnt16", stall_cnt, 14);
        repeat (15) step();
        #1;
        check("sat_cnt4_held", stall_cnt4, 15);
        check("sat_cnt16", stall_cnt, 29);
        check("sat_head_held", mem_wdata, 4'h5);
        check("sat_we", mem_we, 0);
        check("sat_wr_rq", wr_rq, 1);

        // Reset while TWO and full
        in_valid = 1'b1; in_data = 4'h6;
        step();
        in_valid = 1'b0;
        #1;
        check("mid_two_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_we", mem_we, 0);
        step();
        rst = 1'b0; full = 1'b0;
        wq.delete(); aq.delete();
        #1;
        check("mid_post_wr_rq", wr_rq, 0);
        check("mid_post_we", mem_we, 0);
        check("mid_post_ready", in_ready, 1);
        check("mid_post_wr_cnt", wr_cnt, 0);
        check("mid_post_stall_cnt", stall_cnt, 0);
        check("mid_post_stalled", stalled, 0);
        in_valid = 1'b1; in_data = 4'hB;
        step();
        in_valid = 1'b0;
        #1;
        check("mid_first_we", mem_we, 1);
        check("mid_first_data", mem_wdata, 4'hB);
        check("mid_first_addr", mem_waddr, 1);
        step();
        step();
        #1;
        check("mid_wr_cnt", wr_cnt, 1);
        check("mid_write_count", wq.size(), 1);
        if (wq.size() > 0) check("mid_only_word", wq[0], 4'hB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wr_ingress.md
Name: wr_ingress

Overview:
- Write-side front end of the async FIFO. Lives entirely in the write clock domain, directly upstream of the write-pointer/full stage.
- Accepts a valid/ready stream from the producer and buffers it in a 2-entry skid buffer.
- Drives wr_rq into the full stage and takes back its registered full flag and binary waddr.
- Produces the dual-port RAM write strobe, address and data, plus write/stall statistics.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 8, FIFO depth (power of 2); sets AW = $clog2(DEPTH).
- CNT_W, 16, width of the statistics counters.

Ports:
- w_clk  input  1  write-domain clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  producer data.
- wr_rq  output  1  write request to the full stage.
- full  input  1  registered full flag from the full stage.
- waddr  input  AW  binary write address from the full stage.
- mem_we  output  1  RAM write enable.
- mem_waddr  output  AW  RAM write address.
- mem_wdata  output  WIDTH  RAM write data.
- wr_cnt  output  CNT_W  committed writes; wraps modulo 2^CNT_W.
- stall_cnt  output  CNT_W  cycles with wr_rq=1 and full=1; saturates at all-ones.
- stalled  output  1  sticky flag: at least one full-stall cycle since reset.

Behaviour:
- Clock and reset: one clock, w_clk. rst is synchronous and active-high.
- State: the skid buffer occupancy FSM has three states, EMPTY(0), ONE(1) and TWO(2). It holds two data registers: head (oldest word) and tail.
- Reset (rst=1 sampled at the edge):
  - state <= EMPTY; head, tail, wr_cnt and stall_cnt <= 0; stalled <= 0.
  - in_ready = 0 while rst is high (gated combinationally).
  - wr_rq and mem_we are 0 after the reset edge.
  - Reset mid-operation discards any buffered words. Nothing is written to RAM.
- Combinational outputs:
  - in_ready = !rst && state != TWO. It does not depend on full, so there is no combinational path from full to in_ready.
  - wr_rq = (state != EMPTY).
  - commit = wr_rq && !full.
  - accept = in_valid && in_ready.
  - mem_we = commit; mem_waddr = waddr (pass-through); mem_wdata = head.
- Transitions (next = occupancy + accept - commit):
  - EMPTY: accept -> ONE, head <= in_data. wr_rq=0, so commit is impossible.
  - ONE: accept & commit -> ONE, head <= in_data. accept only -> TWO, tail <= in_data. commit only -> EMPTY. Neither -> ONE.
  - TWO: commit -> ONE, head <= tail. in_ready=0, so accept is impossible.
- Latency: a word accepted at edge N raises wr_rq after edge N. It commits in the first following cycle with full=0.
- Ordering: strict FIFO order is preserved. No word is dropped or duplicated.
- Full handling:
  - While full=1, wr_rq stays asserted and head is held stable.
  - The full stage ignores wr_rq while full. mem_we is 0.
- Counters:
  - wr_cnt increments by 1 on each commit and wraps to 0.
  - stall_cnt increments on each cycle with wr_rq && full and holds at 2^CNT_W-1.
  - stalled is set on the first such cycle and cleared only by rst.
- Simultaneous events:
  - Accept and commit in the same cycle in state ONE keeps one word buffered, with full throughput.
  - Sustained in_valid=1 with full=0 gives one write per cycle after the first.
- Address: RAM wrap-around is owned by the full stage. mem_waddr simply follows waddr (DEPTH-1 -> 0).

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> in_ready=0, wr_rq=0, mem_we=0, wr_cnt=0, stall_cnt=0, stalled=0.
- Streaming: full=0, send 0x1..0x8 back-to-back from waddr 0 -> mem_we on 8 consecutive cycles starting 1 cycle after the first accept. mem_wdata=1..8 at mem_waddr=0..7. wr_cnt=8.
- Backpressure: full=1 held, send 0xA, 0xB, 0xC -> in_ready drops after 2 accepts, mem_we=0, head=0xA held. Then release full=0 -> writes 0xA, 0xB, 0xC in order. stall_cnt equals the stall cycles; stalled=1.
- Toggling full every cycle with continuous in_valid -> no loss or duplication; RAM holds the input sequence in order.
- Saturation: CNT_W=4, full=1 with a word buffered for 20 cycles -> stall_cnt=15 and holds.
- Reset mid-operation: state=TWO with full=1, assert rst for 1 cycle -> state EMPTY, no mem_we; the next accepted word is the first one written.
